sw_scan_ctrl: RTL and testbench
===============================

// Module: sw_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for a bank of N_SW slide switches/buttons.
//  One shared divider paces a scan pointer round-robin over the switches. Each
//  visit samples the synchronized switch and detects a rising edge. An edge
//  toggles that switch's LED and queues an event. Pending events drain
//  round-robin through a valid/ready port to the downstream consumer.
// PARAMETERS
//  N_SW       4   number of switches/LEDs (>=2); ID_W = $clog2(N_SW) localparam
//  DIV_RATIO  10  clk cycles per scan tick (>=2)
// PORTS
//  clk         in   1     system clock; single clock domain
//  rst         in   1     synchronous, active-high reset
//  sw          in   N_SW  raw asynchronous switch inputs
//  led         out  N_SW  per-switch toggle state
//  ev_valid    out  1     event available
//  ev_ready    in   1     consumer accepts event
//  ev_id       out  ID_W  index of switch that produced the event
//  ev_overrun  out  1     1-cycle pulse: edge arrived while its event already pending
// BEHAVIOUR
//  Reset: sync regs, last-sample regs, led, pending, ev_valid, ev_id, ev_overrun = 0;
//   div = 0; tick = 0; scan_idx = 0; rr_last = N_SW-1 (first grant search starts at 0).
//   Reset mid-operation discards all pending and in-flight events. No ev_overrun pulse.
//  Sync: 2-FF synchronizer per bit; sync_q[i] is sw[i] delayed 2 clks.
//  Divider: div counts 0..DIV_RATIO-1 and wraps. Registered tick = 1 for exactly one
//   clk after div == DIV_RATIO-1, so there is one tick per DIV_RATIO clks.
//  Scan: on a tick cycle, act on index scan_idx, then scan_idx <= (scan_idx == N_SW-1) ? 0 : +1.
//   Each switch is visited once per N_SW*DIV_RATIO clks.
//  Visit of index k: edge = !last[k] && sync_q[k]; last[k] <= sync_q[k].
//   Falling edges update last[k] only.
//   On edge: led[k] toggles, visible the clk after the tick.
//   On edge: pending[k] <= 1.
//   If pending[k] is already 1 and is not being loaded this cycle: ev_overrun = 1 for one clk.
//   The event is merged, not queued twice.
//  Output stage is a registered ev_valid/ev_id.
//   Load condition: (!ev_valid || ev_ready) && |pending.
//    When it holds, grant the first set pending bit searching (rr_last+1) .. wrapping.
//    On grant: ev_id <= grant, ev_valid <= 1, rr_last <= grant, pending[grant] cleared.
//   Else if ev_ready: ev_valid <= 0.
//   Rules: ev_id stable while ev_valid && !ev_ready.
//   Full throughput: one event per clk when ev_ready is held high.
//  Simultaneous edge on k and load of pending[k] in the same clk: set wins.
//   pending[k] stays 1, no overrun, and k is emitted again later.
//  ev_ready while !ev_valid is ignored.
//  Edge-to-ev_valid latency: 1 clk after the visiting tick if the output stage is free.
//  Worst case from sw change: 2 (sync) + N_SW*DIV_RATIO + 1 (tick reg) + 1 clks.
// TESTING (N_SW=4, DIV_RATIO=4 unless noted)
//  1 Hold rst 3 clks with random sw -> led=0, ev_valid=0, ev_overrun=0. First visit after release is idx 0.
//  2 ev_ready=1; sw[2] 0->1 held -> led[2]=1 within 2+16+2 clks; ev_valid one clk, ev_id=2; no further events.
//  3 ev_ready=0; press sw0, sw1, sw3 -> ev_valid=1, ev_id=0 held stable;
//    then ev_ready=1 -> ids 0,1,3 on 3 consecutive clks, then ev_valid=0.
//  4 ev_ready=0, ev 0 in output stage; sw1 rise, fall, rise across 3 visits -> ev_overrun pulses once.
//    led[1] toggles twice (=0); a single id=1 event is emitted after ready.
//  5 Round-robin: after granting id 3, pending {0,2} -> next ids 0 then 2;
//    after granting id 0, pending {0,3} -> 3 then 0.
//  6 Assert rst for 1 clk while ev_valid=1 and pending!=0 -> all state cleared next clk.
//    No stale event emitted; scan restarts at idx 0.

Source files
------------

// File: rtl/sw_scan_ctrl.sv
// sw_scan_ctrl: paced round-robin switch scanner with edge-toggled LEDs and a valid/ready event port
module sw_scan_ctrl #(
    parameter int N_SW      = 4,
    parameter int DIV_RATIO = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_SW-1:0]         sw,
    output logic [N_SW-1:0]         led,
    output logic                    ev_valid,
    input  logic                    ev_ready,
    output logic [$clog2(N_SW)-1:0] ev_id,
    output logic                    ev_overrun
);
    localparam int ID_W  = $clog2(N_SW);
    localparam int DIV_W = $clog2(DIV_RATIO);

    logic [N_SW-1:0]  sync_m;
    logic [N_SW-1:0]  sync_q;
    logic [N_SW-1:0]  last;
    logic [N_SW-1:0]  pending;
    logic [DIV_W-1:0] div;
    logic             tick;
    logic [ID_W-1:0]  scan_idx;
    logic [ID_W-1:0]  rr_last;
    logic [ID_W-1:0]  grant;
    logic [N_SW-1:0]  visit_mask;
    logic [N_SW-1:0]  edge_mask;
    logic [N_SW-1:0]  grant_mask;
    logic             load;
    logic             overrun;

    // round-robin pick: lowest pending index overall, overridden by the lowest one above rr_last
    always_comb begin
        grant = '0;
        for (int i = N_SW - 1; i >= 0; i--)
            if (pending[i]) grant = ID_W'(i);
        for (int i = N_SW - 1; i >= 0; i--)
            if (pending[i] && ID_W'(i) > rr_last) grant = ID_W'(i);
    end

    // visit decode, edge detection, output-stage load and overrun condition
    always_comb begin
        visit_mask = tick ? N_SW'(1) << scan_idx : '0;
        edge_mask  = visit_mask & sync_q & ~last;
        load       = (!ev_valid || ev_ready) && |pending;
        grant_mask = load ? N_SW'(1) << grant : '0;
        overrun    = |(edge_mask & pending & ~grant_mask);
    end

    // input synchronizer, tick divider and scan pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_m   <= '0;
            sync_q   <= '0;
            div      <= '0;
            tick     <= 1'b0;
            scan_idx <= '0;
        end else begin
            sync_m   <= sw;
            sync_q   <= sync_m;
            div      <= (div == DIV_W'(DIV_RATIO - 1)) ? '0 : div + DIV_W'(1);
            tick     <= div == DIV_W'(DIV_RATIO - 1);
            if (tick) scan_idx <= (scan_idx == ID_W'(N_SW - 1)) ? '0 : scan_idx + ID_W'(1);
        end
    end

    // per-switch state: last sample, LED toggle and pending flags (a new edge beats a same-cycle grant)
    always_ff @(posedge clk) begin
        if (rst) begin
            last       <= '0;
            led        <= '0;
            pending    <= '0;
            ev_overrun <= 1'b0;
        end else begin
            last       <= (last & ~visit_mask) | (sync_q & visit_mask);
            led        <= led ^ edge_mask;
            pending    <= (pending & ~grant_mask) | edge_mask;
            ev_overrun <= overrun;
        end
    end

    // registered event output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            ev_valid <= 1'b0;
            ev_id    <= '0;
            rr_last  <= ID_W'(N_SW - 1);
        end else if (load) begin
            ev_valid <= 1'b1;
            ev_id    <= grant;
            rr_last  <= grant;
        end else if (ev_ready) begin
            ev_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sw_scan_ctrl.sv
// tb_sw_scan_ctrl: scoreboard bench for sw_scan_ctrl with a visit-level reference model
module tb_sw_scan_ctrl;
    localparam int N  = 4;
    localparam int D  = 4;
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ev_ready = 1'b0;
    logic [N-1:0]  sw = '0;
    logic [N-1:0]  led;
    logic          ev_valid;
    logic          ev_overrun;
    logic [IW-1:0] ev_id;

    int checks = 0;
    int errors = 0;

    sw_scan_ctrl #(.N_SW(N), .DIV_RATIO(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .led       (led),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_id     (ev_id),
        .ev_overrun(ev_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // reference model: edge count since reset decides which switch is visited
    int           p = 0;
    int           m_rr = N - 1;
    int           mk = 0;
    int           mg = -1;
    bit           mld = 1'b0;
    bit           me = 1'b0;
    bit           m_valid = 1'b0;
    bit           m_ovr = 1'b0;
    logic [N-1:0] h1 = '0;
    logic [N-1:0] h2 = '0;
    logic [N-1:0] m_last = '0;
    logic [N-1:0] m_led = '0;
    logic [N-1:0] m_pend = '0;
    int           exp_q[$];

    // model update on each clock edge using the inputs present at that edge
    always @(posedge clk) begin
        if (rst) begin
            p = 0; h1 = '0; h2 = '0; m_last = '0; m_led = '0; m_pend = '0;
            m_valid = 1'b0; m_ovr = 1'b0; m_rr = N - 1;
            exp_q.delete();
        end else begin
            p++;
            mld = (!m_valid || ev_ready) && m_pend != '0;
            mg = -1;
            for (int j = 1; j <= N; j++)
                if (mg < 0 && m_pend[IW'((m_rr + j) % N)]) mg = (m_rr + j) % N;
            me = 1'b0;
            if (p >= 2 && (p - 1) % D == 0) begin
                mk = ((p - 1) / D - 1) % N;
                me = !m_last[IW'(mk)] && h2[IW'(mk)];
                m_last[IW'(mk)] = h2[IW'(mk)];
            end
            m_ovr = me && m_pend[IW'(mk)] && !(mld && mg == mk);
            if (mld) begin
                m_pend[IW'(mg)] = 1'b0;
                m_valid = 1'b1;
                m_rr = mg;
                exp_q.push_back(mg);
            end else if (ev_ready) begin
                m_valid = 1'b0;
            end
            if (me) begin
                m_pend[IW'(mk)] = 1'b1;
                m_led[IW'(mk)] = !m_led[IW'(mk)];
            end
            h2 = h1;
            h1 = sw;
        end
    end

    // monitor: compares every cycle and pops the scoreboard whenever a new event is presented
    bit v_prev = 1'b0;
    bit hs_prev = 1'b0;
    int id_prev = 0;
    int acc_q[$];
    int ovr_cnt = 0;
    always @(negedge clk) begin
        chk("led", int'(led), int'(m_led));
        chk("overrun", int'(ev_overrun), int'(m_ovr));
        chk("valid", int'(ev_valid), int'(m_valid));
        if (ev_overrun) ovr_cnt++;
        if (ev_valid) begin
            if (!v_prev || hs_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_event: got id %0d expected none at %0t", ev_id, $time);
                end else begin
                    chk("ev_id", int'(ev_id), exp_q.pop_front());
                end
            end else begin
                chk("ev_id_stable", int'(ev_id), id_prev);
            end
        end
        hs_prev = ev_valid && ev_ready && !rst;
        if (hs_prev) acc_q.push_back(int'(ev_id));
        v_prev = ev_valid;
        id_prev = int'(ev_id);
    end

    int base;
    int t;
    int obase;
    bit led1;
    logic [N-1:0] flip;

    initial begin
        // reset held 3 clks with random switches
        @(posedge clk); #1; sw = N'($urandom);
        @(negedge clk);
        chk("rst_led", int'(led), 0);
        chk("rst_valid", int'(ev_valid), 0);
        chk("rst_overrun", int'(ev_overrun), 0);
        @(posedge clk); #1; sw = N'($urandom);
        @(posedge clk); #1; rst = 1'b0; sw = 4'b0001; ev_ready = 1'b1;
        // first visit after release is index 0
        step(5);
        @(negedge clk);
        chk("first_visit_led", int'(led), 1);
        step(4);
        @(negedge clk);
        chk("second_visit_led", int'(led), 1);
        @(posedge clk); #1; sw = '0;
        step(24);

        // single press of switch 2 with ready held high
        base = acc_q.size();
        sw = 4'b0100;
        t = 0;
        while (!led[2] && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("t2_led2", int'(led[2]), 1);
        @(posedge clk); #1;
        step(40);
        chk("t2_event_count", acc_q.size() - base, 1);
        if (acc_q.size() > base) chk("t2_event_id", acc_q[base], 2);

        // stalled consumer, then burst drain 0,1,3
        ev_ready = 1'b0;
        sw = 4'b0101;
        step(20);
        sw = 4'b1111;
        step(20);
        @(negedge clk);
        chk("t3_valid", int'(ev_valid), 1);
        chk("t3_id", int'(ev_id), 0);
        @(posedge clk); #1;
        base = acc_q.size();
        ev_ready = 1'b1;
        step(4);
        chk("t3_burst_count", acc_q.size() - base, 3);
        if (acc_q.size() >= base + 3) begin
            chk("t3_burst_0", acc_q[base], 0);
            chk("t3_burst_1", acc_q[base + 1], 1);
            chk("t3_burst_2", acc_q[base + 2], 3);
        end
        @(negedge clk);
        chk("t3_idle", int'(ev_valid), 0);

        // overrun: switch 1 rises twice while its event is still pending
        @(posedge clk); #1;
        ev_ready = 1'b0;
        sw = 4'b1100;
        step(20);
        sw = 4'b1101;
        step(20);
        obase = ovr_cnt;
        led1 = led[1];
        sw = 4'b1111;
        step(16);
        sw = 4'b1101;
        step(16);
        sw = 4'b1111;
        step(20);
        @(negedge clk);
        chk("t4_overrun_pulses", ovr_cnt - obase, 1);
        chk("t4_led1_twice", int'(led[1]), int'(led1));
        @(posedge clk); #1;
        base = acc_q.size();
        ev_ready = 1'b1;
        step(6);
        chk("t4_event_count", acc_q.size() - base, 2);
        if (acc_q.size() >= base + 2) begin
            chk("t4_first_id", acc_q[base], 0);
            chk("t4_merged_id", acc_q[base + 1], 1);
        end

        // reset while an event is presented and another is pending
        ev_ready = 1'b0;
        sw = '0;
        step(20);
        sw = 4'b0011;
        step(20);
        @(negedge clk);
        chk("t6_valid_before", int'(ev_valid), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        sw = '0;
        ev_ready = 1'b1;
        @(negedge clk);
        chk("t6_valid_after", int'(ev_valid), 0);
        chk("t6_led_after", int'(led), 0);
        @(posedge clk); #1;
        base = acc_q.size();
        step(40);
        chk("t6_no_stale", acc_q.size() - base, 0);

        // randomized traffic with sparse switch toggles and a random consumer
        for (int c = 0; c < 3000; c++) begin
            flip = '0;
            for (int b = 0; b < N; b++) flip = (flip << 1) | N'($urandom_range(15) == 0);
            sw = sw ^ flip;
            ev_ready = $urandom_range(9) < 7;
            rst = (c == 1500);
            step(1);
        end
        rst = 1'b0;
        ev_ready = 1'b1;
        step(100);
        chk("drain_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
